key_event_queue: RTL and testbench

Consumer end of the keypad scan interface: samples the debounced `ready`/`keycode` pair from the keypad scanner and converts the level-style key state into discrete press and release events. Events are buffered in a small FIFO and handed to the downstream note/sequencer logic through a valid/ready handshake. It sits directly between the keypad scanner and the melody control logic, in the same clock domain as the scanner.

---
 rtl/key_event_pkg.sv | 35 +++
 rtl/key_event_fifo.sv | 60 ++++++
 rtl/key_event_queue.sv | 178 +++++++++++++++++
 tb/tb_key_event_queue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg
//   Shared definitions for the keypad event queue: keycode layout constants,
//   the packed event record stored in the FIFO, the FSM state encoding and a
//   helper that decides whether the scanner reports a usable key.
//   The optional auto-repeat feature is selected with the KEY_REPEAT_EN macro
//   in key_event_queue.sv.
package key_event_pkg;

    localparam int         KEYCODE_W   = 5;
    localparam logic [2:0] COL_INVALID = 3'h7;
    localparam logic [2:0] COL_MAX     = 3'd4;

    // One queued event; rpt is the auto-repeat flag ("repeat" is a keyword).
    typedef struct packed {
        logic                 rpt;
        logic                 press;
        logic [KEYCODE_W-1:0] code;
    } key_event_t;

    localparam int EVENT_W = $bits(key_event_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_CHANGE = 2'd2
    } key_state_e;

    // keycode is {col[2:0], row[1:0]}; columns above COL_MAX (including
    // COL_INVALID) mean the scanner has nothing usable.
    function automatic logic key_is_down(input logic ready,
                                         input logic [KEYCODE_W-1:0] code);
        return ready && (code[4:2] <= COL_MAX);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo
//   First-word-fall-through FIFO for key events. The head entry is always
//   presented on pop_data; it is meaningful only while empty=0.
//   Ports:
//     clk, rst_n       clock, async active-low reset
//     push, push_data  write request (ignored when full unless a pop is taken)
//     pop              read request (ignored when empty)
//     pop_data         head entry
//     full, empty      occupancy flags
module key_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]                  wr_ptr_q, wr_ptr_d;
    logic [AW:0]                  rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q;
    logic                         pop_ok;
    logic                         push_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok = push & (~full | pop_ok);

    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue
//   Turns the scanner's level-style ready/keycode pair into discrete press and
//   release events, queued in a FWFT FIFO with a valid/ready output.
//   Optional feature: define KEY_REPEAT_EN to emit auto-repeat events while a
//   key stays held (first after REPEAT_DELAY cycles, then every REPEAT_PERIOD).
//   Ports:
//     clk, rst_n          clock (shared with scanner), async active-low reset
//     ready, keycode      scanner outputs, keycode = {col[2:0], row[1:0]}
//     ev_valid, ev_ready  event handshake; pop on ev_valid & ev_ready
//     ev_press, ev_repeat, ev_code   head event fields
//     overflow, ov_clr    sticky drop flag and its synchronous clear
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ready,
    input  logic [KEYCODE_W-1:0] keycode,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic                 ev_press,
    output logic                 ev_repeat,
    output logic [KEYCODE_W-1:0] ev_code,
    output logic                 overflow,
    input  logic                 ov_clr
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] HELD   = ST_HELD;
    localparam logic [1:0] CHANGE = ST_CHANGE;

    logic [1:0]           state_q, state_d;
    logic [KEYCODE_W-1:0] held_q, held_d;
    logic                 overflow_q, overflow_d;
    logic                 key_down;
    logic                 push;
    key_event_t           push_ev;
    key_event_t           head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_ok;
    logic                 ov_set;
    logic                 repeat_hit;

    assign key_down = key_is_down(ready, keycode);

`ifdef KEY_REPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] FIRST_LIM = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] NEXT_LIM  = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;   // still waiting for the first repeat

    assign repeat_hit = (state_q == HELD) && key_down && (keycode == held_q) &&
                        (cnt_q == (first_q ? FIRST_LIM : NEXT_LIM));

    // Outside HELD the counter is parked at zero, so entering HELD from IDLE
    // or CHANGE always starts a fresh delay.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        first_d = first_q;
        if (state_q != HELD) begin
            cnt_d   = '0;
            first_d = 1'b1;
        end else if (repeat_hit) begin
            cnt_d   = '0;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign ev_repeat = head.rpt;
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
    logic unused_rpt;

    assign repeat_hit = 1'b0;
    assign ev_repeat  = 1'b0;
    assign unused_rpt = head.rpt;
`endif

    // Event FSM: at most one push per cycle. Release/change branches come
    // before the repeat branch, so they win over a coincident repeat.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        push    = 1'b0;
        push_ev = '{rpt: 1'b0, press: 1'b1, code: held_q};
        case (state_q)
            IDLE: begin
                if (key_down) begin
                    held_d       = keycode;
                    push         = 1'b1;
                    push_ev.code = keycode;
                    state_d      = HELD;
                end
            end
            HELD: begin
                if (!key_down) begin
                    push          = 1'b1;
                    push_ev.press = 1'b0;
                    state_d       = IDLE;
                end else if (keycode != held_q) begin
                    push          = 1'b1;
                    push_ev.press = 1'b0;
                    held_d        = keycode;
                    state_d       = CHANGE;
                end else if (repeat_hit) begin
                    push        = 1'b1;
                    push_ev.rpt = 1'b1;
                end
            end
            CHANGE: begin
                // Key-up here is picked up next cycle from HELD.
                push    = 1'b1;
                state_d = HELD;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop_ok = ev_valid & ev_ready;
    // A drop only happens when the FIFO stays full through this cycle.
    assign ov_set = push & fifo_full & ~pop_ok;

    always_comb begin
        overflow_d = overflow_q;
        if (ov_set)      overflow_d = 1'b1;
        else if (ov_clr) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            held_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            overflow_q <= overflow_d;
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_ev),
        .pop       (ev_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ev_valid = ~fifo_empty;
    assign ev_press = head.press;
    assign ev_code  = head.code;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue
//   Self-checking bench for key_event_queue. Inputs change 1 ns after each
//   rising edge; a monitor on the falling edge compares every popped event
//   against a scoreboard of expected events {repeat, press, code}.
//   Build with +define+KEY_REPEAT_EN to exercise the auto-repeat path.
module tb_key_event_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ready;
    logic [4:0] keycode;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_press;
    logic       ev_repeat;
    logic [4:0] ev_code;
    logic       overflow;
    logic       ov_clr;

    int checks   = 0;
    int failures = 0;

    logic [6:0] sb[$];

    always #5 clk = ~clk;

    key_event_queue #(
        .DEPTH         (8),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ready     (ready),
        .keycode   (keycode),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_press  (ev_press),
        .ev_repeat (ev_repeat),
        .ev_code   (ev_code),
        .overflow  (overflow),
        .ov_clr    (ov_clr)
    );

    function automatic logic [6:0] ev(input logic r, input logic p, input logic [4:0] c);
        return {r, p, c};
    endfunction

    // Scoreboard consumer: every accepted pop must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got=%b", {ev_repeat, ev_press, ev_code});
            end else begin
                logic [6:0] exp_ev;
                exp_ev = sb.pop_front();
                if ({ev_repeat, ev_press, ev_code} !== exp_ev) begin
                    failures++;
                    $display("FAIL event_order got=%b expected=%b", {ev_repeat, ev_press, ev_code}, exp_ev);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && ev_valid === 1'b0) begin
                done = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_drain pending=%0d ev_valid=%b required pending=0 ev_valid=0", name, sb.size(), ev_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({ev_valid, ev_press, ev_repeat, ev_code, overflow} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=0", {ev_valid, ev_press, ev_repeat, ev_code, overflow});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        ev_ready = 1'b1;
        sb.push_back(ev(0, 1, 5'h0A));
        sb.push_back(ev(0, 0, 5'h0A));
        ready = 1'b1; keycode = 5'b01010;
        tick();
        checks++;
        if (ev_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency ev_valid=%b required=1", ev_valid);
        end
        tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_single_press ev_valid=%b required=0", ev_valid);
        end
        repeat (8) tick();
        ready = 1'b0;
        wait_drain("basic");
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_overflow got=%b required=0", overflow);
        end
    endtask

    task automatic test_change();
        ev_ready = 1'b1;
        sb.push_back(ev(0, 1, 5'h03));
        sb.push_back(ev(0, 0, 5'h03));
        sb.push_back(ev(0, 1, 5'h11));
        sb.push_back(ev(0, 0, 5'h11));
        ready = 1'b1; keycode = 5'h03;
        repeat (4) tick();
        keycode = 5'h11;
        tick();
        checks++;
        if (ev_valid !== 1'b1 || ev_press !== 1'b0 || ev_code !== 5'h03) begin
            failures++;
            $display("FAIL change_release got v=%b p=%b c=%h required v=1 p=0 c=03", ev_valid, ev_press, ev_code);
        end
        tick();
        checks++;
        if (ev_valid !== 1'b1 || ev_press !== 1'b1 || ev_code !== 5'h11) begin
            failures++;
            $display("FAIL change_press got v=%b p=%b c=%h required v=1 p=1 c=11", ev_valid, ev_press, ev_code);
        end
        repeat (3) tick();
        ready = 1'b0;
        wait_drain("change");
    endtask

    task automatic test_overflow();
        logic [4:0] codes [5] = '{5'h00, 5'h05, 5'h0A, 5'h0F, 5'h10};
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                sb.push_back(ev(0, 1, codes[i]));
                sb.push_back(ev(0, 0, codes[i]));
            end
            ready = 1'b1; keycode = codes[i];
            tick();
            ready = 1'b0;
            tick();
        end
        checks++;
        if (overflow !== 1'b1 || ev_valid !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set overflow=%b ev_valid=%b required 1 1", overflow, ev_valid);
        end
        ev_ready = 1'b1;
        wait_drain("overflow");
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky got=%b required=1", overflow);
        end
        ov_clr = 1'b1;
        tick();
        ov_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear got=%b required=0", overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [4:0] codes [4] = '{5'h01, 5'h06, 5'h0B, 5'h0C};
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(ev(0, 1, codes[i]));
            sb.push_back(ev(0, 0, codes[i]));
            ready = 1'b1; keycode = codes[i];
            tick();
            ready = 1'b0;
            tick();
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_no_drop overflow=%b required=0", overflow);
        end
        sb.push_back(ev(0, 1, 5'h12));
        sb.push_back(ev(0, 0, 5'h12));
        ready = 1'b1; keycode = 5'h12; ev_ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop overflow=%b required=0", overflow);
        end
        wait_drain("full_pop");
    endtask

    task automatic test_invalid();
        ev_ready = 1'b1;
        ready = 1'b1; keycode = 5'b11111;
        repeat (5) tick();
        keycode = 5'b10111;
        repeat (3) tick();
        ready = 1'b0; keycode = 5'h0A;
        repeat (3) tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL invalid_no_event ev_valid=%b required=0", ev_valid);
        end
        wait_drain("invalid");
    endtask

    task automatic test_reset_mid_hold();
        ev_ready = 1'b0;
        ready = 1'b1; keycode = 5'h02;
        tick();
        ready = 1'b0;
        tick();
        ready = 1'b1; keycode = 5'h0C;
        repeat (3) tick();
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({ev_valid, ev_press, ev_repeat, ev_code, overflow} !== 9'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b required=0", {ev_valid, ev_press, ev_repeat, ev_code, overflow});
        end
        tick();
        sb.push_back(ev(0, 1, 5'h0C));
        sb.push_back(ev(0, 0, 5'h0C));
        rst_n = 1'b1; ev_ready = 1'b1;
        tick();
        checks++;
        if (ev_valid !== 1'b1 || ev_press !== 1'b1 || ev_code !== 5'h0C) begin
            failures++;
            $display("FAIL midreset_press got v=%b p=%b c=%h required v=1 p=1 c=0c", ev_valid, ev_press, ev_code);
        end
        repeat (3) tick();
        ready = 1'b0;
        wait_drain("midreset");
    endtask

    task automatic test_repeat();
        ev_ready = 1'b1;
        sb.push_back(ev(0, 1, 5'h07));
`ifdef KEY_REPEAT_EN
        for (int i = 0; i < 4; i++) sb.push_back(ev(1, 1, 5'h07));
`endif
        sb.push_back(ev(0, 0, 5'h07));
        ready = 1'b1; keycode = 5'h07;
        repeat (25) tick();
        ready = 1'b0;
        wait_drain("repeat");
    endtask

    initial begin
        ready = 1'b0; keycode = '0; ev_ready = 1'b0; ov_clr = 1'b0;
        test_reset();
        test_basic();
        test_change();
        test_overflow();
        test_full_pop();
        test_invalid();
        test_reset_mid_hold();
        test_repeat();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
